elevator_call_controller: RTL and testbench



---
 rtl/elevator_pkg.sv | 23 ++
 rtl/elevator_call_select.sv | 65 ++++++
 rtl/elevator_call_controller.sv | 148 ++++++++++++++
 tb/tb_elevator_call_controller.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Types and constants shared by the elevator and its call-side controller.
package elevator_pkg;

  localparam int unsigned FLOORS = 4;

  typedef logic [1:0] floor_t;

  typedef enum logic [2:0] {
    IDLE,
    DISPATCH,
    TRAVEL,
    DOOR,
    FAULT
  } call_state_t;

  function automatic logic [FLOORS-1:0] floor_mask(input floor_t f);
    logic [FLOORS-1:0] m;
    m    = '0;
    m[f] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/elevator_call_select.sv
// Combinational SCAN target selection: keep the current direction while calls
// remain ahead of the car, otherwise reverse toward the nearest call behind it.
module elevator_call_select
  import elevator_pkg::*;
(
  input  logic [FLOORS-1:0] pending,
  input  logic [1:0]        current_floor,
  input  logic              dir_up,
  output logic [1:0]        target,
  output logic              target_valid,
  output logic              at_floor,
  output logic              next_dir_up
);

  logic   have_above;
  logic   have_below;
  floor_t lo_above;
  floor_t hi_below;

  always_comb begin
    have_above = 1'b0;
    have_below = 1'b0;
    lo_above   = current_floor;
    hi_below   = current_floor;
    // Ascending scan: first hit above is the nearest, last hit below is the nearest.
    for (int unsigned i = 0; i < FLOORS; i++) begin
      if (pending[i]) begin
        if (i > 32'(current_floor)) begin
          if (!have_above) begin
            lo_above   = floor_t'(i);
            have_above = 1'b1;
          end
        end else if (i < 32'(current_floor)) begin
          hi_below   = floor_t'(i);
          have_below = 1'b1;
        end
      end
    end
  end

  always_comb begin
    at_floor     = pending[current_floor];
    target_valid = |pending;
    target       = current_floor;
    next_dir_up  = dir_up;
    if (!at_floor) begin
      if (dir_up) begin
        if (have_above) begin
          target = lo_above;
        end else if (have_below) begin
          target      = hi_below;
          next_dir_up = 1'b0;
        end
      end else begin
        if (have_below) begin
          target = hi_below;
        end else if (have_above) begin
          target      = lo_above;
          next_dir_up = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/elevator_call_controller.sv
// Call-side controller: latches floor calls, dispatches SCAN targets to the
// elevator via rfloor, holds the door interval and flags travel timeouts.
module elevator_call_controller
  import elevator_pkg::*;
#(
  parameter int unsigned DOOR_CYCLES  = 50,
  parameter int unsigned TRAVEL_LIMIT = 1000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [FLOORS-1:0] call_btn,
  input  logic [1:0]        current_floor,
  input  logic              up,
  input  logic              down,
  input  logic              stop,
  output logic [1:0]        rfloor,
  output logic [FLOORS-1:0] pending,
  output logic              door_open,
  output logic              busy,
  output logic              fault
);

  localparam int unsigned DW = $clog2(DOOR_CYCLES + 1);
  localparam int unsigned TW = $clog2(TRAVEL_LIMIT + 1);

  call_state_t       state;
  call_state_t       state_next;
  logic              dir_up;
  logic [DW-1:0]     door_cnt;
  logic [TW-1:0]     travel_cnt;

  logic [1:0]        sel_target;
  logic              sel_valid;
  logic              sel_at_floor;
  logic              sel_next_dir_up;

  logic              arrive;
  logic              travel_expired;
  logic              door_reload;
  logic              door_done;
  logic              dispatch_here;
  logic              dispatch_go;
  logic [FLOORS-1:0] serve_mask;

  logic              unused_motion;
  assign unused_motion = up ^ down;

  elevator_call_select u_select (
    .pending       (pending),
    .current_floor (current_floor),
    .dir_up        (dir_up),
    .target        (sel_target),
    .target_valid  (sel_valid),
    .at_floor      (sel_at_floor),
    .next_dir_up   (sel_next_dir_up)
  );

  always_comb begin
    arrive         = (state == TRAVEL) && stop && (current_floor == rfloor);
    travel_expired = (state == TRAVEL) && !arrive &&
                     (travel_cnt >= TW'(TRAVEL_LIMIT - 1));
    door_reload    = (state == DOOR) && call_btn[current_floor];
    door_done      = (state == DOOR) && !door_reload && (door_cnt == '0);
    dispatch_here  = (state == DISPATCH) && sel_at_floor;
    dispatch_go    = (state == DISPATCH) && sel_valid && !sel_at_floor;
  end

  // The floor being served masks its own button, so an arrival-edge press loses to the clear.
  always_comb begin
    serve_mask = '0;
    if (arrive) begin
      serve_mask = floor_mask(rfloor);
    end else if (dispatch_here || (state == DOOR)) begin
      serve_mask = floor_mask(current_floor);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (|pending) state_next = DISPATCH;
      end
      DISPATCH: begin
        if (sel_at_floor)   state_next = DOOR;
        else if (sel_valid) state_next = TRAVEL;
        else                state_next = IDLE;
      end
      TRAVEL: begin
        if (arrive)              state_next = DOOR;
        else if (travel_expired) state_next = FAULT;
      end
      DOOR: begin
        if (door_done) state_next = (|pending) ? DISPATCH : IDLE;
      end
      FAULT: state_next = FAULT;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    door_open = (state == DOOR);
    fault     = (state == FAULT);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending <= '0;
      rfloor  <= '0;
      dir_up  <= 1'b1;
    end else begin
      pending <= (pending | call_btn) & ~serve_mask;
      if (dispatch_go) rfloor <= sel_target;
      if ((state == DISPATCH) && sel_valid) dir_up <= sel_next_dir_up;
    end
  end

  // Counter holds DOOR_CYCLES-1 on entry so the door stays open DOOR_CYCLES cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      door_cnt <= '0;
    end else if (arrive || dispatch_here || door_reload) begin
      door_cnt <= DW'(DOOR_CYCLES - 1);
    end else if ((state == DOOR) && (door_cnt != '0)) begin
      door_cnt <= door_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      travel_cnt <= '0;
    end else if (dispatch_go) begin
      travel_cnt <= '0;
    end else if ((state == TRAVEL) && (travel_cnt != TW'(TRAVEL_LIMIT))) begin
      travel_cnt <= travel_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_elevator_call_controller.sv
// Directed bench for elevator_call_controller: dispatch vector table plus
// multi-cycle door, SCAN, fault and reset sequences.
module tb_elevator_call_controller;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] call_btn;
  logic [1:0] current_floor;
  logic       up, down, stop;
  logic [1:0] rfloor;
  logic [3:0] pending;
  logic       door_open, busy, fault;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  elevator_call_controller #(
    .DOOR_CYCLES  (50),
    .TRAVEL_LIMIT (1000)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .call_btn      (call_btn),
    .current_floor (current_floor),
    .up            (up),
    .down          (down),
    .stop          (stop),
    .rfloor        (rfloor),
    .pending       (pending),
    .door_open     (door_open),
    .busy          (busy),
    .fault         (fault)
  );

  typedef struct {
    logic [1:0] cf;
    logic [3:0] btn;
    logic [1:0] exp_rfloor;
    logic       exp_door;
    logic [3:0] exp_pend;
  } vec_t;

  vec_t vecs[7];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic do_reset;
    reset_n  = 1'b0;
    call_btn = '0;
    stop     = 1'b0;
    up       = 1'b0;
    down     = 1'b0;
    tick;
    tick;
    reset_n = 1'b1;
  endtask

  task automatic press(input logic [3:0] b);
    call_btn = b;
    tick;
    call_btn = '0;
  endtask

  task automatic door_len(output int n);
    n = 0;
    while (door_open === 1'b1 && n < 500) begin
      n++;
      tick;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int n;
    vecs[0] = '{2'd0, 4'b0100, 2'd2, 1'b0, 4'b0100};
    vecs[1] = '{2'd1, 4'b1001, 2'd3, 1'b0, 4'b1001};
    vecs[2] = '{2'd2, 4'b0011, 2'd1, 1'b0, 4'b0011};
    vecs[3] = '{2'd3, 4'b0101, 2'd2, 1'b0, 4'b0101};
    vecs[4] = '{2'd1, 4'b0010, 2'd0, 1'b1, 4'b0000};
    vecs[5] = '{2'd0, 4'b1110, 2'd1, 1'b0, 4'b1110};
    vecs[6] = '{2'd2, 4'b1100, 2'd0, 1'b1, 4'b1000};

    current_floor = 2'd0;
    reset_n  = 1'b0;
    call_btn = '0;
    stop = 1'b0; up = 1'b0; down = 1'b0;
    #3;
    check("reset_rfloor",  rfloor,    0);
    check("reset_pending", pending,   0);
    check("reset_door",    door_open, 0);
    check("reset_busy",    busy,      0);
    check("reset_fault",   fault,     0);

    for (int i = 0; i < 7; i++) begin
      do_reset;
      current_floor = vecs[i].cf;
      press(vecs[i].btn);
      check($sformatf("v%0d_latch", i), pending, vecs[i].btn);
      check($sformatf("v%0d_busy1", i), busy, 0);
      tick;
      check($sformatf("v%0d_rfloor2", i), rfloor, 0);
      check($sformatf("v%0d_busy2", i), busy, 1);
      tick;
      check($sformatf("v%0d_rfloor", i),  rfloor,    vecs[i].exp_rfloor);
      check($sformatf("v%0d_door", i),    door_open, vecs[i].exp_door);
      check($sformatf("v%0d_pending", i), pending,   vecs[i].exp_pend);
    end

    // Basic trip to floor 2 and door interval.
    do_reset;
    current_floor = 2'd0;
    press(4'b0100);
    tick; tick;
    check("a_rfloor", rfloor, 2);
    current_floor = 2'd2; stop = 1'b1;
    tick;
    check("a_door_rise", door_open, 1);
    check("a_clear",     pending,   0);
    door_len(n);
    check("a_door_len", n,    50);
    check("a_idle",     busy, 0);
    stop = 1'b0;

    // SCAN: from floor 1 heading up, serve 3 then 0.
    do_reset;
    current_floor = 2'd1;
    press(4'b1001);
    tick; tick;
    check("b_first", rfloor, 3);
    current_floor = 2'd3; stop = 1'b1;
    tick;
    check("b_pend_after3", pending, 1);
    door_len(n);
    check("b_door3", n, 50);
    tick;
    check("b_second", rfloor, 0);
    current_floor = 2'd0;
    tick;
    check("b_door0", door_open, 1);
    door_len(n);
    check("b_door0_len", n,    50);
    check("b_idle",      busy, 0);
    stop = 1'b0;

    // Direction reversal sticks: down at floor 1 picks 0 over 2.
    do_reset;
    current_floor = 2'd3;
    press(4'b0011);
    tick; tick;
    check("c_first", rfloor, 1);
    press(4'b0100);
    check("c_latch_travel", pending, 4'b0111);
    current_floor = 2'd1; stop = 1'b1;
    tick;
    check("c_pend", pending, 4'b0101);
    door_len(n);
    tick;
    check("c_down_pick", rfloor, 0);
    stop = 1'b0;

    // Door extension by a press at the serving floor.
    do_reset;
    current_floor = 2'd0;
    press(4'b0100);
    tick; tick;
    current_floor = 2'd2; stop = 1'b1;
    tick;
    n = 0;
    while (door_open === 1'b1 && n < 500) begin
      n++;
      if (n == 40) call_btn = 4'b0100;
      tick;
      call_btn = '0;
      if (n == 40) check("d_no_latch", pending[2], 0);
    end
    check("d_door_len", n, 90);
    check("d_idle", busy, 0);
    stop = 1'b0;

    // Travel timeout, including a stop at a non-target floor.
    do_reset;
    current_floor = 2'd0;
    press(4'b1000);
    tick; tick;
    check("e_rfloor", rfloor, 3);
    n = 0;
    while (fault !== 1'b1 && n < 2000) begin
      if (n == 100) begin current_floor = 2'd1; stop = 1'b1; end
      if (n == 110) stop = 1'b0;
      tick;
      n++;
    end
    check("e_fault_time", n, 1000);
    press(4'b0010);
    check("e_latch", pending, 4'b1010);
    tick; tick; tick;
    check("e_rfloor_frozen", rfloor,    3);
    check("e_fault_sticky",  fault,     1);
    check("e_no_door",       door_open, 0);

    // Asynchronous reset mid-travel.
    do_reset;
    current_floor = 2'd0;
    press(4'b1110);
    tick; tick;
    check("f_travel_rfloor", rfloor, 1);
    check("f_pending", pending, 4'b1110);
    #2;
    reset_n = 1'b0;
    #1;
    check("f_rst_rfloor",  rfloor,    0);
    check("f_rst_pending", pending,   0);
    check("f_rst_busy",    busy,      0);
    check("f_rst_door",    door_open, 0);
    check("f_rst_fault",   fault,     0);
    tick;
    reset_n = 1'b1;
    press(4'b0010);
    tick;
    check("f_post_rfloor2", rfloor, 0);
    tick;
    check("f_post_rfloor", rfloor, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
